bus_cs_decoder: RTL and testbench
=================================

Name: bus_cs_decoder

Overview:
- Registered 68000 address/chip-select decoder that feeds the DTACK generator with active-low RAM/ROM even/odd and DUART selects.
- Implements the reset boot overlay: ROM is mirrored at 0x000000 for the first BOOT_CYCLES bus cycles, so the CPU can fetch its SSP and PC.
- Provides ROM write protection, unmapped-address detection and a bus-error watchdog that drives BERR when DTACK never arrives.

Parameters:
- RAM_SEL, 4'h0, addr[23:20] value selecting RAM.
- IO_SEL, 4'hE, addr[23:20] value selecting the DUART.
- ROM_SEL, 4'hF, addr[23:20] value selecting ROM.
- BOOT_CYCLES, 4, completed bus cycles during which the overlay is active (two long-word vector reads).
- BERR_TIMEOUT, 64, clocks from select assertion to BERR if DTACK has not been seen (minimum 2).

Ports:
- clk  in  1  CPU clock; all inputs are synchronous to it.
- reset  in  1  synchronous, active-high reset.
- as_n  in  1  68000 address strobe, active low.
- uds_n  in  1  upper data strobe (even byte), active low.
- lds_n  in  1  lower data strobe (odd byte), active low.
- rw  in  1  1 = read, 0 = write.
- addr  in  23  CPU A[23:1].
- dtack_n  in  1  DTACK returned by the DTACK generator, active low.
- ram_evn_cs  out  1  RAM even-byte select, active low.
- ram_odd_cs  out  1  RAM odd-byte select, active low.
- rom_evn_cs  out  1  ROM even-byte select, active low.
- rom_odd_cs  out  1  ROM odd-byte select, active low.
- duart_cs  out  1  DUART select, active low.
- berr_n  out  1  bus error to CPU, active low.
- boot_overlay  out  1  1 while the overlay is in force.

Behaviour:
- Reset values, forced on any clk edge with reset=1: all selects 1, berr_n 1, boot_overlay 1, boot counter 0, timer 0, state IDLE, armed 0.
- Reset mid-cycle: outputs drop immediately. A cycle already in progress is never decoded. armed is set only after as_n has been sampled 1.
- States:
  - IDLE: if armed and as_n=0, decode the sampled addr, rw, uds_n and lds_n. A valid decode goes to ACTIVE with selects asserted on that same edge, giving 1-clock latency from AS. An invalid decode goes to BERR with berr_n=0 on that edge.
  - ACTIVE: selects held. Timer increments each clock until dtack_n=0 has been sampled, after which it is frozen. If the timer reaches BERR_TIMEOUT-1 without DTACK, go to BERR and deassert the selects on that edge. If as_n=1, go to IDLE, deassert the selects and increment the boot counter.
  - BERR: berr_n=0 and all selects 1. If as_n=1, go to IDLE with berr_n=1. Aborted cycles count toward the boot counter.
- Decode on addr[23:20]:
  - ROM_SEL: ROM.
  - RAM_SEL: ROM if boot_overlay=1 and rw=1. Otherwise RAM; overlay writes go to RAM.
  - IO_SEL: duart_cs. Either strobe asserts the DUART select.
  - Anything else is invalid (unmapped).
- ROM write with rw=0: invalid, so BERR is raised and no select is asserted.
- Byte lanes: evn follows uds_n=0 and odd follows lds_n=0, sampled at decode. If both strobes are 1 at the decode edge, stay in IDLE and re-sample next clock, because the strobes lag AS on writes.
- Boot counter: 3 bits, saturating. boot_overlay clears on the edge where the counter reaches BOOT_CYCLES and stays 0 until reset.
- Simultaneous as_n=1 and timeout in ACTIVE: as_n wins; go to IDLE with no BERR.
- At most one region's selects are low at any time. Selects never change in the middle of a cycle.

Decomposition:
- Package raven_bus_pkg:
  - region select constants RAM_SEL, IO_SEL, ROM_SEL;
  - state enum {IDLE, ACTIVE, BERR};
  - a decode-result typedef carrying ram, rom, io, invalid, evn and odd fields.
- One sub-module, bus_timeout_timer: start/clear/freeze counter with a timeout flag, parameterised by BERR_TIMEOUT.

Test Plan:
- Reset released with as_n=1, then 4 word reads at 0x000000, 0x000002, 0x000004, 0x000006 (uds_n=lds_n=0, dtack at +2 clk) -> rom_evn_cs and rom_odd_cs go 0 one clock after as_n falls. boot_overlay goes 0 after the 4th as_n rise. A 5th read at 0x000000 asserts ram_evn_cs and ram_odd_cs.
- Overlay active, byte write lds_n=0 to 0x000101 -> only ram_odd_cs goes 0; the boot counter advances.
- Write to 0xF00000 -> no select asserted, berr_n=0 one clock after AS, released on the as_n rise.
- Read 0x500000 (unmapped) -> berr_n=0 one clock after AS. Read 0xE00001 with dtack_n held 1 -> duart_cs=0, then berr_n=0 and duart_cs=1 BERR_TIMEOUT clocks after select assertion.
- reset pulsed while ram_evn_cs=0 and as_n still 0 -> all selects 1 on the next edge; no select until as_n goes 1 then 0. boot_overlay=1 again. as_n rise coinciding with timeout -> berr_n stays 1.

Source files
------------

// File: rtl/bus_cs_decoder_pkg.sv
// Shared definitions for the 68000 chip-select decoder: region codes, FSM states
// and the combinational decode result.
package raven_bus_pkg;

  localparam logic [3:0] RAM_SEL = 4'h0;
  localparam logic [3:0] IO_SEL  = 4'hE;
  localparam logic [3:0] ROM_SEL = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    BERR   = 2'd2
  } state_e;

  typedef struct packed {
    logic ram;
    logic rom;
    logic io;
    logic invalid;
    logic evn;
    logic odd;
  } dec_t;

endpackage

// File: rtl/bus_cs_decoder_if.sv
// CPU-side bus bundle between the 68000, the chip-select decoder and the DTACK generator.
interface bus_cs_decoder_if;
  logic        as_n;
  logic        uds_n;
  logic        lds_n;
  logic        rw;
  logic [23:1] addr;
  logic        dtack_n;
  logic        ram_evn_cs;
  logic        ram_odd_cs;
  logic        rom_evn_cs;
  logic        rom_odd_cs;
  logic        duart_cs;
  logic        berr_n;
  logic        boot_overlay;

  modport master (
    output as_n, uds_n, lds_n, rw, addr, dtack_n,
    input  ram_evn_cs, ram_odd_cs, rom_evn_cs, rom_odd_cs, duart_cs, berr_n, boot_overlay
  );

  modport slave (
    input  as_n, uds_n, lds_n, rw, addr, dtack_n,
    output ram_evn_cs, ram_odd_cs, rom_evn_cs, rom_odd_cs, duart_cs, berr_n, boot_overlay
  );
endinterface

// File: rtl/bus_cs_decoder_timer.sv
// Bus-cycle watchdog: cleared on start, counts while running until DTACK is seen,
// then freezes. timeout_o flags the edge on which the count would reach the limit.
module bus_timeout_timer #(
  parameter int BERR_TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic run_i,
  input  logic dtack_i,
  output logic timeout_o
);
  localparam int CW = $clog2(BERR_TIMEOUT) + 1;
  localparam logic [CW-1:0] LAST = CW'(BERR_TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          seen_q, seen_d;

  always_comb begin
    cnt_d  = cnt_q;
    seen_d = seen_q;
    if (start_i) begin
      cnt_d  = '0;
      seen_d = 1'b0;
    end else if (run_i) begin
      if (dtack_i)      seen_d = 1'b1;
      else if (!seen_q) cnt_d  = cnt_q + CW'(1);
    end
  end

  // A DTACK sampled on the same edge as the limit still rescues the cycle.
  assign timeout_o = run_i && !start_i && !seen_q && !dtack_i && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      seen_q <= seen_d;
    end
  end
endmodule

// File: rtl/bus_cs_decoder.sv
// Registered 68000 chip-select decoder with boot ROM overlay, ROM write protection,
// unmapped-address bus error and a DTACK watchdog.
module bus_cs_decoder
  import raven_bus_pkg::*;
#(
  parameter logic [3:0] RAM_SEL      = raven_bus_pkg::RAM_SEL,
  parameter logic [3:0] IO_SEL       = raven_bus_pkg::IO_SEL,
  parameter logic [3:0] ROM_SEL      = raven_bus_pkg::ROM_SEL,
  parameter int         BOOT_CYCLES  = 4,
  parameter int         BERR_TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            reset,
  bus_cs_decoder_if.slave bus
);

  state_e     state_q, state_d;
  logic [4:0] sel_q, sel_d;    // active-high {ram_e, ram_o, rom_e, rom_o, io}
  logic       berr_q, berr_d;
  logic       ovl_q, ovl_d;
  logic       armed_q, armed_d;
  logic [2:0] boot_q, boot_d;
  logic       tmr_start, tmr_timeout, cyc_done;
  dec_t       dec;
  logic [3:0] region;
  logic       unused_addr;

  assign region      = bus.addr[23:20];
  assign unused_addr = ^bus.addr[19:1];

  always_comb begin
    dec     = '0;
    dec.evn = !bus.uds_n;
    dec.odd = !bus.lds_n;
    if (region == ROM_SEL) begin
      if (bus.rw) dec.rom     = 1'b1;
      else        dec.invalid = 1'b1;
    end else if (region == RAM_SEL) begin
      // Overlay mirrors ROM for reads only; writes fall through to RAM.
      if (ovl_q && bus.rw) dec.rom = 1'b1;
      else                 dec.ram = 1'b1;
    end else if (region == IO_SEL) begin
      dec.io = 1'b1;
    end else begin
      dec.invalid = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    berr_d    = berr_q;
    armed_d   = armed_q | bus.as_n;
    tmr_start = 1'b0;
    cyc_done  = 1'b0;
    case (state_q)
      IDLE: begin
        // Strobes lag AS on writes: wait until at least one is low.
        if (armed_q && !bus.as_n && !(bus.uds_n && bus.lds_n)) begin
          if (dec.invalid) begin
            state_d = BERR;
            berr_d  = 1'b1;
          end else begin
            state_d   = ACTIVE;
            sel_d     = {dec.ram & dec.evn, dec.ram & dec.odd,
                         dec.rom & dec.evn, dec.rom & dec.odd, dec.io};
            tmr_start = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (bus.as_n) begin
          state_d  = IDLE;
          sel_d    = '0;
          cyc_done = 1'b1;
        end else if (tmr_timeout) begin
          state_d = BERR;
          sel_d   = '0;
          berr_d  = 1'b1;
        end
      end
      BERR: begin
        if (bus.as_n) begin
          state_d  = IDLE;
          berr_d   = 1'b0;
          cyc_done = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
        berr_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    boot_d = boot_q;
    ovl_d  = ovl_q;
    if (cyc_done && boot_q != 3'd7) boot_d = boot_q + 3'd1;
    if (cyc_done && boot_d == 3'(BOOT_CYCLES)) ovl_d = 1'b0;
  end

  bus_timeout_timer #(
    .BERR_TIMEOUT(BERR_TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .start_i  (tmr_start),
    .run_i    (state_q == ACTIVE),
    .dtack_i  (!bus.dtack_n),
    .timeout_o(tmr_timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      berr_q  <= 1'b0;
      ovl_q   <= 1'b1;
      armed_q <= 1'b0;
      boot_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      berr_q  <= berr_d;
      ovl_q   <= ovl_d;
      armed_q <= armed_d;
      boot_q  <= boot_d;
    end
  end

  assign bus.ram_evn_cs   = ~sel_q[4];
  assign bus.ram_odd_cs   = ~sel_q[3];
  assign bus.rom_evn_cs   = ~sel_q[2];
  assign bus.rom_odd_cs   = ~sel_q[1];
  assign bus.duart_cs     = ~sel_q[0];
  assign bus.berr_n       = ~berr_q;
  assign bus.boot_overlay = ovl_q;

endmodule

// File: tb/tb_bus_cs_decoder.sv
// Directed bench for bus_cs_decoder: boot overlay, lane selects, bus errors,
// watchdog timing and reset mid-cycle.
module tb_bus_cs_decoder;
  localparam int T = 64;

  // Expected select patterns, active low: {ram_e, ram_o, rom_e, rom_o, duart}
  localparam logic [4:0] NONE  = 5'b11111;
  localparam logic [4:0] ROMW  = 5'b11001;
  localparam logic [4:0] RAMW  = 5'b00111;
  localparam logic [4:0] RAMO  = 5'b10111;
  localparam logic [4:0] RAME  = 5'b01111;
  localparam logic [4:0] DUART = 5'b11110;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [4:0] cs;

  bus_cs_decoder_if bus();

  bus_cs_decoder #(.BERR_TIMEOUT(T)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign cs = {bus.ram_evn_cs, bus.ram_odd_cs, bus.rom_evn_cs, bus.rom_odd_cs, bus.duart_cs};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic start_cycle(input logic [23:0] baddr, input logic rw, input logic uds_n,
                             input logic lds_n);
    bus.addr  = 23'(baddr >> 1);
    bus.rw    = rw;
    bus.uds_n = uds_n;
    bus.lds_n = lds_n;
    bus.as_n  = 1'b0;
  endtask

  task automatic end_cycle();
    bus.as_n    = 1'b1;
    bus.uds_n   = 1'b1;
    bus.lds_n   = 1'b1;
    bus.dtack_n = 1'b1;
    step();
  endtask

  // Word read with DTACK two clocks after AS; checks select latency and release.
  task automatic word_read(input string tag, input logic [23:0] baddr, input logic [4:0] exp);
    start_cycle(baddr, 1'b1, 1'b0, 1'b0);
    step();
    chk({tag, "_sel"}, 8'(cs), 8'(exp));
    step();
    bus.dtack_n = 1'b0;
    step();
    chk({tag, "_hold"}, 8'(cs), 8'(exp));
    end_cycle();
    chk({tag, "_rel"}, 8'(cs), 8'(NONE));
  endtask

  initial begin
    reset       = 1'b1;
    bus.as_n    = 1'b1;
    bus.uds_n   = 1'b1;
    bus.lds_n   = 1'b1;
    bus.rw      = 1'b1;
    bus.addr    = '0;
    bus.dtack_n = 1'b1;
    step();
    chk("rst_cs", 8'(cs), 8'(NONE));
    chk("rst_berr", 8'(bus.berr_n), 8'd1);
    chk("rst_ovl", 8'(bus.boot_overlay), 8'd1);
    reset = 1'b0;
    step();

    // Boot vector fetch through the overlay
    word_read("boot0", 24'h000000, ROMW);
    chk("ovl_after1", 8'(bus.boot_overlay), 8'd1);
    word_read("boot1", 24'h000002, ROMW);
    word_read("boot2", 24'h000004, ROMW);
    word_read("boot3", 24'h000006, ROMW);
    chk("ovl_after4", 8'(bus.boot_overlay), 8'd0);
    word_read("ram0", 24'h000000, RAMW);

    // ROM write is protected
    start_cycle(24'hF00000, 1'b0, 1'b0, 1'b0);
    step();
    chk("romwr_cs", 8'(cs), 8'(NONE));
    chk("romwr_berr", 8'(bus.berr_n), 8'd0);
    step();
    chk("romwr_berr_hold", 8'(bus.berr_n), 8'd0);
    end_cycle();
    chk("romwr_berr_rel", 8'(bus.berr_n), 8'd1);

    // Unmapped read
    start_cycle(24'h500000, 1'b1, 1'b0, 1'b0);
    step();
    chk("unmap_berr", 8'(bus.berr_n), 8'd0);
    chk("unmap_cs", 8'(cs), 8'(NONE));
    end_cycle();
    chk("unmap_rel", 8'(bus.berr_n), 8'd1);

    // DUART read without DTACK: watchdog fires T clocks after select
    start_cycle(24'hE00001, 1'b1, 1'b1, 1'b0);
    step();
    chk("duart_sel", 8'(cs), 8'(DUART));
    for (int i = 0; i < T - 1; i++) step();
    chk("duart_pre_to_cs", 8'(cs), 8'(DUART));
    chk("duart_pre_to_berr", 8'(bus.berr_n), 8'd1);
    step();
    chk("duart_to_berr", 8'(bus.berr_n), 8'd0);
    chk("duart_to_cs", 8'(cs), 8'(NONE));
    end_cycle();
    chk("duart_to_rel", 8'(bus.berr_n), 8'd1);

    // Strobes lagging AS on a write: decode waits for a strobe
    start_cycle(24'h000010, 1'b0, 1'b1, 1'b1);
    step();
    chk("lag_idle", 8'(cs), 8'(NONE));
    bus.uds_n = 1'b0;
    step();
    chk("lag_evn", 8'(cs), 8'(RAME));
    end_cycle();

    // DTACK seen early freezes the watchdog
    start_cycle(24'h000200, 1'b1, 1'b0, 1'b0);
    step();
    bus.dtack_n = 1'b0;
    step();
    bus.dtack_n = 1'b1;
    for (int i = 0; i < T + 2; i++) step();
    chk("frz_cs", 8'(cs), 8'(RAMW));
    chk("frz_berr", 8'(bus.berr_n), 8'd1);
    end_cycle();

    // Reset pulsed in the middle of a RAM cycle
    start_cycle(24'h000100, 1'b1, 1'b0, 1'b0);
    step();
    chk("mid_sel", 8'(cs), 8'(RAMW));
    reset = 1'b1;
    step();
    chk("mid_rst_cs", 8'(cs), 8'(NONE));
    chk("mid_rst_ovl", 8'(bus.boot_overlay), 8'd1);
    reset = 1'b0;
    step();
    step();
    chk("mid_noarm", 8'(cs), 8'(NONE));
    end_cycle();

    // Overlay write goes to RAM, odd lane only, and counts toward boot
    start_cycle(24'h000101, 1'b0, 1'b1, 1'b0);
    step();
    chk("ovlwr_sel", 8'(cs), 8'(RAMO));
    end_cycle();
    word_read("b2_0", 24'h000000, ROMW);
    word_read("b2_1", 24'h000002, ROMW);
    chk("ovl_b2_3", 8'(bus.boot_overlay), 8'd1);
    word_read("b2_2", 24'h000004, ROMW);
    chk("ovl_b2_4", 8'(bus.boot_overlay), 8'd0);

    // AS rise on the timeout edge wins over BERR
    start_cycle(24'hE00001, 1'b1, 1'b1, 1'b0);
    step();
    chk("race_sel", 8'(cs), 8'(DUART));
    for (int i = 0; i < T - 1; i++) step();
    end_cycle();
    chk("race_berr", 8'(bus.berr_n), 8'd1);
    chk("race_cs", 8'(cs), 8'(NONE));
    step();
    chk("race_berr_after", 8'(bus.berr_n), 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
